// File: rtl/issue_queue_pkg.sv
// Shared types for the out-of-order issue queue: renamed instruction,
// reservation-station row, operand/tag widths and FU class.
package issue_queue_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned PREG_W = 6;
    localparam int unsigned ROB_W  = 5;
    localparam int unsigned FU_W   = 2;

    typedef logic [XLEN-1:0]   word;
    typedef logic [PREG_W-1:0] p_reg;
    typedef logic [ROB_W-1:0]  rob_idx;

    typedef enum logic {
        FU_ALU,
        FU_MEM
    } fu_class_e;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        p_reg       preg_dst;
        p_reg       preg_src0;
        p_reg       preg_src1;
    } rename_struct;

    typedef struct packed {
        logic [3:0]      alu_op;
        logic            mem_read;
        logic            mem_write;
        p_reg            preg_dst;
        p_reg            preg_src0;
        p_reg            preg_src1;
        logic            src0_ready;
        logic            src1_ready;
        word             src0;
        word             src1;
        rob_idx          rob;
        logic [FU_W-1:0] fu;
    } rs_row_struct;

    // Operand capture result: hit doubles as "source ready".
    typedef struct packed {
        logic hit;
        word  data;
    } wake_res_t;

    function automatic fu_class_e fu_class(input logic mem_read, input logic mem_write);
        return (mem_read || mem_write) ? FU_MEM : FU_ALU;
    endfunction

endpackage

// File: rtl/issue_queue_select.sv
// Oldest-first selector: grants the requesting entry that has no older
// requesting entry according to the age matrix (age[i][j] = j older than i).
module iq_select #(
    parameter int unsigned DEPTH = 16
) (
    input  logic [DEPTH-1:0][DEPTH-1:0] age,
    input  logic [DEPTH-1:0]            ready,
    input  logic [DEPTH-1:0]            class_mask,
    output logic [DEPTH-1:0]            grant
);

    logic [DEPTH-1:0] req;

    always_comb begin
        req = ready & class_mask;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            grant[i] = req[i] & ~(|(age[i] & req));
        end
    end

endmodule

// File: rtl/issue_queue.sv
// Out-of-order issue queue: dispatch with operand capture, wakeup from
// completion broadcasts, age-ordered select with ALU/MEM class steering.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned DISP_W  = 2,
    parameter int unsigned ISSUE_W = 3,
    parameter int unsigned WAKE_W  = 3
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_flush,
    input  logic [DISP_W-1:0]               i_disp_valid,
    input  rename_struct [DISP_W-1:0]       i_disp_inst,
    input  word [DISP_W-1:0][1:0]           i_disp_src_data,
    input  logic [DISP_W-1:0][1:0]          i_disp_src_rdy,
    input  rob_idx [DISP_W-1:0]             i_disp_rob,
    output logic                            o_disp_ready,
    input  logic [WAKE_W-1:0]               i_wake_valid,
    input  p_reg [WAKE_W-1:0]               i_wake_preg,
    input  word [WAKE_W-1:0]                i_wake_data,
    input  logic [ISSUE_W-1:0]              i_fu_ready,
    output logic [ISSUE_W-1:0]              o_issue_valid,
    output rs_row_struct [ISSUE_W-1:0]      o_issue_inst,
    output logic [$clog2(DEPTH):0]          o_free_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam int unsigned N_ALU = ISSUE_W - 1;

    logic [DEPTH-1:0]            valid;
    rs_row_struct                rows [DEPTH];
    logic [DEPTH-1:0][DEPTH-1:0] age;

    logic [DEPTH-1:0] ready_vec;
    logic [DEPTH-1:0] alu_mask;
    logic [DEPTH-1:0] mem_mask;
    wake_res_t        wake0 [DEPTH];
    wake_res_t        wake1 [DEPTH];

    logic [DEPTH-1:0] alu_avail [N_ALU+1];
    logic [DEPTH-1:0] alu_grant [N_ALU];
    logic [DEPTH-1:0] mem_oldest;
    logic [DEPTH-1:0] issue_grant [ISSUE_W];
    rs_row_struct     issue_row [ISSUE_W];
    logic [ISSUE_W-1:0] issue_go;
    logic [DEPTH-1:0] issued_mask;

    logic [DISP_W-1:0] alloc_en;
    logic [IDX_W-1:0]  alloc_idx [DISP_W];
    logic [DEPTH-1:0]  new_age [DISP_W];
    rs_row_struct      new_row [DISP_W];
    logic [DEPTH-1:0]  alloc_mask;

    logic [DEPTH-1:0]  valid_n;
    logic [CNT_W-1:0]  free_n;
    logic              disp_ready_n;

    // Lowest-index broadcast port wins when several carry the same tag.
    function automatic wake_res_t wake_lookup(
        input p_reg                tag,
        input logic [WAKE_W-1:0]   wv,
        input p_reg [WAKE_W-1:0]   wp,
        input word [WAKE_W-1:0]    wd
    );
        wake_res_t r;
        r = '0;
        for (int unsigned w = 0; w < WAKE_W; w++) begin
            if (!r.hit && wv[w] && wp[w] == tag) begin
                r.hit  = 1'b1;
                r.data = wd[w];
            end
        end
        return r;
    endfunction

    function automatic wake_res_t capture_src(
        input p_reg      tag,
        input logic      rdy_in,
        input word       data_in,
        input wake_res_t wr
    );
        wake_res_t r;
        if (tag == '0) begin
            r.hit  = 1'b1;
            r.data = '0;
        end else if (wr.hit) begin
            r = wr;
        end else begin
            r.hit  = rdy_in;
            r.data = data_in;
        end
        return r;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ready_vec[i] = valid[i] & rows[i].src0_ready & rows[i].src1_ready;
            mem_mask[i]  = (fu_class(rows[i].mem_read, rows[i].mem_write) == FU_MEM);
            alu_mask[i]  = ~mem_mask[i];
            wake0[i]     = wake_lookup(rows[i].preg_src0, i_wake_valid, i_wake_preg, i_wake_data);
            wake1[i]     = wake_lookup(rows[i].preg_src1, i_wake_valid, i_wake_preg, i_wake_data);
        end
    end

    // ALU ports claim candidates in port order; a port that is not ready
    // leaves its pick available to the next port.
    assign alu_avail[0] = ready_vec;

    for (genvar p = 0; p < N_ALU; p++) begin : g_alu_sel
        iq_select #(.DEPTH(DEPTH)) u_alu_sel (
            .age        (age),
            .ready      (alu_avail[p]),
            .class_mask (alu_mask),
            .grant      (alu_grant[p])
        );
        assign alu_avail[p+1] = alu_avail[p] & ~(i_fu_ready[p] ? alu_grant[p] : '0);
    end

    // MEM picks the oldest valid MEM entry regardless of readiness, so a
    // younger ready load/store can never pass an older waiting one.
    iq_select #(.DEPTH(DEPTH)) u_mem_sel (
        .age        (age),
        .ready      (valid),
        .class_mask (mem_mask),
        .grant      (mem_oldest)
    );

    always_comb begin
        issued_mask = '0;
        for (int unsigned p = 0; p < ISSUE_W; p++) begin
            if (p < N_ALU) begin
                issue_grant[p] = i_fu_ready[p] ? alu_grant[p] : '0;
            end else begin
                issue_grant[p] = (i_fu_ready[p] && |(mem_oldest & ready_vec)) ? mem_oldest : '0;
            end
            issue_row[p] = '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (issue_grant[p][i]) begin
                    issue_row[p] = issue_row[p] | rows[i];
                end
            end
            issue_row[p].fu = FU_W'(p);
            issue_go[p]     = |issue_grant[p];
            issued_mask     = issued_mask | issue_grant[p];
        end
    end

    always_comb begin : b_alloc
        logic [DEPTH-1:0] taken;
        logic             found;
        wake_res_t        s0;
        wake_res_t        s1;
        taken      = valid;
        alloc_mask = '0;
        found      = 1'b0;
        s0         = '0;
        s1         = '0;
        for (int unsigned s = 0; s < DISP_W; s++) begin
            alloc_en[s]  = 1'b0;
            alloc_idx[s] = '0;
            new_age[s]   = '0;
            new_row[s]   = '0;
            if (i_disp_valid[s] && o_disp_ready && !i_flush && i_disp_inst[s].alu_op != '0) begin
                found = 1'b0;
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (!found && !taken[i]) begin
                        found        = 1'b1;
                        alloc_idx[s] = IDX_W'(i);
                    end
                end
                alloc_en[s] = found;
                new_age[s]  = taken;
                if (found) begin
                    taken[alloc_idx[s]]      = 1'b1;
                    alloc_mask[alloc_idx[s]] = 1'b1;
                end
                s0 = capture_src(i_disp_inst[s].preg_src0, i_disp_src_rdy[s][0], i_disp_src_data[s][0],
                                 wake_lookup(i_disp_inst[s].preg_src0, i_wake_valid, i_wake_preg, i_wake_data));
                s1 = capture_src(i_disp_inst[s].preg_src1, i_disp_src_rdy[s][1], i_disp_src_data[s][1],
                                 wake_lookup(i_disp_inst[s].preg_src1, i_wake_valid, i_wake_preg, i_wake_data));
                new_row[s].alu_op     = i_disp_inst[s].alu_op;
                new_row[s].mem_read   = i_disp_inst[s].mem_read;
                new_row[s].mem_write  = i_disp_inst[s].mem_write;
                new_row[s].preg_dst   = i_disp_inst[s].preg_dst;
                new_row[s].preg_src0  = i_disp_inst[s].preg_src0;
                new_row[s].preg_src1  = i_disp_inst[s].preg_src1;
                new_row[s].src0_ready = s0.hit;
                new_row[s].src0       = s0.data;
                new_row[s].src1_ready = s1.hit;
                new_row[s].src1       = s1.data;
                new_row[s].rob        = i_disp_rob[s];
            end
        end
    end

    always_comb begin
        valid_n = i_flush ? '0 : ((valid & ~issued_mask) | alloc_mask);
        free_n  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!valid_n[i]) begin
                free_n = free_n + 1'b1;
            end
        end
        disp_ready_n = (free_n >= CNT_W'(DISP_W));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid         <= '0;
            age           <= '0;
            o_issue_valid <= '0;
            o_issue_inst  <= '0;
            o_free_count  <= CNT_W'(DEPTH);
            o_disp_ready  <= 1'b1;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rows[i] <= '0;
            end
        end else begin
            valid        <= valid_n;
            o_free_count <= free_n;
            o_disp_ready <= disp_ready_n;
            if (i_flush) begin
                age           <= '0;
                o_issue_valid <= '0;
                o_issue_inst  <= '0;
            end else begin
                for (int unsigned p = 0; p < ISSUE_W; p++) begin
                    o_issue_valid[p] <= issue_go[p];
                    o_issue_inst[p]  <= issue_go[p] ? issue_row[p] : '0;
                end
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (valid[i] && !rows[i].src0_ready && wake0[i].hit) begin
                        rows[i].src0_ready <= 1'b1;
                        rows[i].src0       <= wake0[i].data;
                    end
                    if (valid[i] && !rows[i].src1_ready && wake1[i].hit) begin
                        rows[i].src1_ready <= 1'b1;
                        rows[i].src1       <= wake1[i].data;
                    end
                end
                // Clear the reused column before writing the new row so that
                // stale "older" bits from the previous occupant never survive.
                for (int unsigned s = 0; s < DISP_W; s++) begin
                    if (alloc_en[s]) begin
                        for (int unsigned i = 0; i < DEPTH; i++) begin
                            age[i][alloc_idx[s]] <= 1'b0;
                        end
                        age[alloc_idx[s]]  <= new_age[s];
                        rows[alloc_idx[s]] <= new_row[s];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue with an issue scoreboard.
module tb_issue_queue;
    import issue_queue_pkg::*;

    localparam int unsigned DEPTH   = 16;
    localparam int unsigned DISP_W  = 2;
    localparam int unsigned ISSUE_W = 3;
    localparam int unsigned WAKE_W  = 3;

    logic                        i_clk;
    logic                        i_rst_n;
    logic                        i_flush;
    logic [DISP_W-1:0]           i_disp_valid;
    rename_struct [DISP_W-1:0]   i_disp_inst;
    word [DISP_W-1:0][1:0]       i_disp_src_data;
    logic [DISP_W-1:0][1:0]      i_disp_src_rdy;
    rob_idx [DISP_W-1:0]         i_disp_rob;
    logic                        o_disp_ready;
    logic [WAKE_W-1:0]           i_wake_valid;
    p_reg [WAKE_W-1:0]           i_wake_preg;
    word [WAKE_W-1:0]            i_wake_data;
    logic [ISSUE_W-1:0]          i_fu_ready;
    logic [ISSUE_W-1:0]          o_issue_valid;
    rs_row_struct [ISSUE_W-1:0]  o_issue_inst;
    logic [$clog2(DEPTH):0]      o_free_count;

    typedef struct {
        int unsigned port;
        rob_idx      rob;
        word         src0;
        word         src1;
    } exp_t;

    exp_t        sb [$];
    int unsigned errors = 0;
    int unsigned checks = 0;

    issue_queue #(
        .DEPTH   (DEPTH),
        .DISP_W  (DISP_W),
        .ISSUE_W (ISSUE_W),
        .WAKE_W  (WAKE_W)
    ) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_flush         (i_flush),
        .i_disp_valid    (i_disp_valid),
        .i_disp_inst     (i_disp_inst),
        .i_disp_src_data (i_disp_src_data),
        .i_disp_src_rdy  (i_disp_src_rdy),
        .i_disp_rob      (i_disp_rob),
        .o_disp_ready    (o_disp_ready),
        .i_wake_valid    (i_wake_valid),
        .i_wake_preg     (i_wake_preg),
        .i_wake_data     (i_wake_data),
        .i_fu_ready      (i_fu_ready),
        .o_issue_valid   (o_issue_valid),
        .o_issue_inst    (o_issue_inst),
        .o_free_count    (o_free_count)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_flush         = 1'b0;
        i_disp_valid    = '0;
        i_disp_inst     = '0;
        i_disp_src_data = '0;
        i_disp_src_rdy  = '0;
        i_disp_rob      = '0;
        i_wake_valid    = '0;
        i_wake_preg     = '0;
        i_wake_data     = '0;
    endtask

    task automatic put_disp(input int unsigned s, input logic [3:0] op, input logic mem,
                            input p_reg s0, input logic r0, input word d0,
                            input p_reg s1, input logic r1, input word d1, input rob_idx rob);
        i_disp_valid[s]       = 1'b1;
        i_disp_inst[s]        = '{alu_op: op, mem_read: mem, mem_write: 1'b0,
                                  preg_dst: p_reg'(rob), preg_src0: s0, preg_src1: s1};
        i_disp_src_rdy[s][0]  = r0;
        i_disp_src_rdy[s][1]  = r1;
        i_disp_src_data[s][0] = d0;
        i_disp_src_data[s][1] = d1;
        i_disp_rob[s]         = rob;
    endtask

    task automatic put_wake(input int unsigned w, input p_reg preg, input word data);
        i_wake_valid[w] = 1'b1;
        i_wake_preg[w]  = preg;
        i_wake_data[w]  = data;
    endtask

    task automatic expect_issue(input int unsigned port, input rob_idx rob, input word s0, input word s1);
        exp_t e;
        e.port = port;
        e.rob  = rob;
        e.src0 = s0;
        e.src1 = s1;
        sb.push_back(e);
    endtask

    task automatic check_issue(input logic [ISSUE_W-1:0] exp_v);
        exp_t e;
        chk("issue_valid", 64'(o_issue_valid), 64'(exp_v));
        for (int p = 0; p < ISSUE_W; p++) begin
            if (o_issue_valid[p]) begin
                chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("issue_fu",   64'(o_issue_inst[p].fu),   64'(e.port));
                    chk("issue_rob",  64'(o_issue_inst[p].rob),  64'(e.rob));
                    chk("issue_src0", 64'(o_issue_inst[p].src0), 64'(e.src0));
                    chk("issue_src1", 64'(o_issue_inst[p].src1), 64'(e.src1));
                end
            end
        end
    endtask

    initial begin
        i_clk      = 1'b0;
        i_rst_n    = 1'b0;
        i_fu_ready = '1;
        idle();
        #12;
        chk("rst_disp_ready", 64'(o_disp_ready), 64'd1);
        chk("rst_free", 64'(o_free_count), 64'd16);
        chk("rst_issue_valid", 64'(o_issue_valid), 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step();

        // Basic issue: two ready ADDs go out on ports 0 and 1
        put_disp(0, 4'd1, 1'b0, 6'd1, 1'b1, 32'h11, 6'd2, 1'b1, 32'h22, 5'd0);
        put_disp(1, 4'd1, 1'b0, 6'd3, 1'b1, 32'h33, 6'd4, 1'b1, 32'h44, 5'd1);
        expect_issue(0, 5'd0, 32'h11, 32'h22);
        expect_issue(1, 5'd1, 32'h33, 32'h44);
        step();
        idle();
        check_issue(3'b000);
        chk("basic_free_held", 64'(o_free_count), 64'd14);
        step();
        check_issue(3'b011);
        chk("basic_free_back", 64'(o_free_count), 64'd16);

        // ALUOp 0 dropped; port 0 busy steers to port 1; p0 source reads zero
        i_fu_ready = 3'b110;
        put_disp(0, 4'd0, 1'b0, 6'd7, 1'b1, 32'h7, 6'd8, 1'b1, 32'h8, 5'd30);
        put_disp(1, 4'd1, 1'b0, 6'd5, 1'b1, 32'h55, 6'd0, 1'b0, 32'hDEAD, 5'd22);
        expect_issue(1, 5'd22, 32'h55, 32'h0);
        step();
        idle();
        check_issue(3'b000);
        chk("drop_free", 64'(o_free_count), 64'd15);
        step();
        check_issue(3'b010);
        i_fu_ready = '1;

        // Wakeup two cycles after dispatch
        put_disp(0, 4'd1, 1'b0, 6'd40, 1'b0, 32'h1234, 6'd0, 1'b1, 32'h0, 5'd2);
        step();
        idle();
        check_issue(3'b000);
        step();
        check_issue(3'b000);
        put_wake(0, 6'd40, 32'h0000_00AA);
        expect_issue(0, 5'd2, 32'hAA, 32'h0);
        step();
        idle();
        check_issue(3'b000);
        step();
        check_issue(3'b001);

        // Same-cycle wake at dispatch; lowest wake port wins
        put_disp(0, 4'd1, 1'b0, 6'd40, 1'b0, 32'h55, 6'd41, 1'b1, 32'h66, 5'd3);
        put_wake(0, 6'd40, 32'hBB);
        put_wake(1, 6'd40, 32'hCC);
        expect_issue(0, 5'd3, 32'hBB, 32'h66);
        step();
        idle();
        check_issue(3'b000);
        step();
        check_issue(3'b001);

        // Fill with 16 waiting instructions
        for (int c = 0; c < 8; c++) begin
            idle();
            put_disp(0, 4'd1, 1'b0, p_reg'(10 + 2*c), 1'b0, 32'h0, 6'd0, 1'b1, 32'h0, rob_idx'(4 + 2*c));
            put_disp(1, 4'd1, 1'b0, p_reg'(11 + 2*c), 1'b0, 32'h0, 6'd0, 1'b1, 32'h0, rob_idx'(5 + 2*c));
            step();
            chk("fill_free", 64'(o_free_count), 64'(16 - 2*(c+1)));
            chk("fill_ready", 64'(o_disp_ready), 64'(c < 7));
            check_issue(3'b000);
        end
        idle();
        put_disp(0, 4'd1, 1'b0, 6'd1, 1'b1, 32'h0, 6'd0, 1'b1, 32'h0, 5'd31);
        step();
        idle();
        chk("full_ignored", 64'(o_free_count), 64'd0);
        check_issue(3'b000);

        // Wake all, three per cycle; issue drains oldest first, two per cycle
        for (int k = 0; k < 16; k++) begin
            expect_issue(k % 2, rob_idx'(4 + k), word'(32'h100 + k), 32'h0);
        end
        for (int c = 0; c < 9; c++) begin
            idle();
            for (int w = 0; w < 3; w++) begin
                if (3*c + w < 16) begin
                    put_wake(w, p_reg'(10 + 3*c + w), word'(32'h100 + 3*c + w));
                end
            end
            step();
            chk("drain_free", 64'(o_free_count), 64'(2*c));
            chk("drain_ready", 64'(o_disp_ready), 64'(c >= 1));
            check_issue((c == 0) ? 3'b000 : 3'b011);
        end
        idle();

        // MEM ordering: younger ready load waits behind older waiting load
        put_disp(0, 4'd2, 1'b1, 6'd50, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0, 5'd20);
        put_disp(1, 4'd2, 1'b1, 6'd51, 1'b1, 32'h51, 6'd0, 1'b1, 32'h0, 5'd21);
        step();
        idle();
        check_issue(3'b000);
        step();
        check_issue(3'b000);
        step();
        check_issue(3'b000);
        put_wake(0, 6'd50, 32'h77);
        expect_issue(2, 5'd20, 32'h77, 32'h0);
        step();
        idle();
        check_issue(3'b000);
        step();
        check_issue(3'b100);
        expect_issue(2, 5'd21, 32'h51, 32'h0);
        step();
        check_issue(3'b100);
        step();
        check_issue(3'b000);
        chk("mem_free", 64'(o_free_count), 64'd16);

        // Flush with 5 waiting entries; same-cycle wake and dispatch ignored
        put_disp(0, 4'd1, 1'b0, 6'd60, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0, 5'd8);
        put_disp(1, 4'd1, 1'b0, 6'd61, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0, 5'd9);
        step();
        idle();
        put_disp(0, 4'd1, 1'b0, 6'd62, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0, 5'd10);
        put_disp(1, 4'd1, 1'b0, 6'd60, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0, 5'd11);
        step();
        idle();
        put_disp(0, 4'd1, 1'b0, 6'd61, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0, 5'd12);
        step();
        idle();
        chk("pre_flush_free", 64'(o_free_count), 64'd11);
        i_flush = 1'b1;
        put_wake(0, 6'd60, 32'h1);
        put_wake(1, 6'd61, 32'h2);
        put_wake(2, 6'd62, 32'h3);
        put_disp(0, 4'd1, 1'b0, 6'd1, 1'b1, 32'h0, 6'd0, 1'b1, 32'h0, 5'd13);
        step();
        idle();
        check_issue(3'b000);
        chk("flush_free", 64'(o_free_count), 64'd16);
        chk("flush_ready", 64'(o_disp_ready), 64'd1);
        step();
        check_issue(3'b000);
        chk("post_flush_free", 64'(o_free_count), 64'd16);

        // Asynchronous reset while issue outputs are high
        put_disp(0, 4'd1, 1'b0, 6'd1, 1'b1, 32'hA1, 6'd2, 1'b1, 32'hA2, 5'd14);
        put_disp(1, 4'd1, 1'b0, 6'd3, 1'b1, 32'hB1, 6'd4, 1'b1, 32'hB2, 5'd15);
        expect_issue(0, 5'd14, 32'hA1, 32'hA2);
        expect_issue(1, 5'd15, 32'hB1, 32'hB2);
        step();
        idle();
        check_issue(3'b000);
        step();
        check_issue(3'b011);
        i_rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(o_issue_valid), 64'd0);
        chk("async_rst_inst", 64'(|o_issue_inst), 64'd0);
        chk("async_rst_free", 64'(o_free_count), 64'd16);
        chk("async_rst_ready", 64'(o_disp_ready), 64'd1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step();
        check_issue(3'b000);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
# issue_queue

Parametrised out-of-order issue queue that sits between rename and the functional units. It accepts up to `DISP_W` renamed instructions per cycle and captures source operands. Pending sources are woken by up to `WAKE_W` completion broadcasts. Each cycle it issues the oldest ready instruction to each free FU port, with ALU and memory ports class-steered. Supports pipeline flush and back-pressure to rename.

## Interface
- `DEPTH`, 16: queue entries, power of two, ≥ 4.
- `DISP_W`, 2: dispatch slots per cycle.
- `ISSUE_W`, 3: FU ports. Ports `0..ISSUE_W-2` are ALU; port `ISSUE_W-1` is MEM.
- `WAKE_W`, 3: completion broadcast ports.
- `i_clk` in 1: clock.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_flush` in 1: synchronous; kills all entries.
- `i_disp_valid` in `[DISP_W]`: slot holds an instruction.
- `i_disp_inst` in `rename_struct [DISP_W]`: renamed instruction.
- `i_disp_src_data` in `word [DISP_W][2]`: register-file read of Src0/Src1.
- `i_disp_src_rdy` in `[DISP_W][2]`: source already produced.
- `i_disp_rob` in `rob_idx [DISP_W]`: ROB tag per slot.
- `o_disp_ready` out 1: all `DISP_W` slots may dispatch this cycle.
- `i_wake_valid` in `[WAKE_W]`: completion broadcast valid.
- `i_wake_preg` in `p_reg [WAKE_W]`: completing destination.
- `i_wake_data` in `word [WAKE_W]`: result value.
- `i_fu_ready` in `[ISSUE_W]`: FU can accept next cycle.
- `o_issue_valid` out `[ISSUE_W]`: issue pulse.
- `o_issue_inst` out `rs_row_struct [ISSUE_W]`: issued entry, with `fu` = port index.
- `o_free_count` out `$clog2(DEPTH)+1`: empty entries.

## Operation
- Entry fields: `valid`, `rs_row_struct` payload, age-matrix row.
- **Dispatch.** A slot is accepted when `i_disp_valid[s] && o_disp_ready`. A slot with `ALUOp==0` is dropped (no entry).
  - Slots take the lowest-index free entries, slot 0 first.
  - Age-matrix row is set to "older than me" for every valid entry and every lower-index slot allocated this cycle.
- **Source capture.**
  - `SrcNReady = i_disp_src_rdy || (wake match this cycle)`. Data is taken from the wake bus on a match, otherwise from `i_disp_src_data`.
  - `p_reg 0` is always ready, with data 0.
- **Wakeup.** For every valid entry and every `i_wake_valid[w]`, if `PRegAddrSrcN == i_wake_preg[w]` and the source is not yet ready: set ready and latch `i_wake_data[w]`. If two ports match the same source, the lowest `w` wins.
- **Class.**
  - MEM: `MemRead || MemWrite`.
  - Otherwise ALU.
- **Select.**
  - Candidates are valid entries with both sources ready at the start of the cycle.
  - For each ALU port `p` in ascending order, with `i_fu_ready[p]`: pick the oldest unclaimed ALU candidate.
  - MEM port: the oldest MEM candidate; MEM instructions issue in age order only. A younger MEM never bypasses an older not-ready MEM.
  - Selected entries are invalidated at the edge.
- **Flush.** Clears every `valid`, `o_issue_valid`, and age matrix. Dispatch and wakeup in the flush cycle are ignored.

## Timing
- **Reset** (`i_rst_n` low, async):
  - all entries invalid;
  - `o_issue_valid` = 0, `o_issue_inst` = 0;
  - `o_disp_ready` = 1, `o_free_count` = `DEPTH`.
- Outputs are registered.
- **Latency.**
  - Dispatch at edge N with ready sources → `o_issue_valid` high after edge N+1.
  - Wakeup at edge N → dependent issue after edge N+1.
- **Back-pressure.** `o_disp_ready` = `free_count ≥ DISP_W`, registered, computed from post-edge occupancy. Entries freed by issue at edge N are reusable from cycle N+1.
- **Issue pulse.** One cycle per entry; no stall or hold. `i_fu_ready` low means no issue on that port.
- **Full.** `o_disp_ready` = 0. Wakeup and issue continue.
- **Simultaneous events.**
  - Dispatch, wakeup and issue in the same cycle are all legal.
  - Wakeup of an entry selected this same cycle is harmless.
- **Flush vs reset.** Flush mid-cycle behaves like reset except it is synchronous; the next cycle shows `o_free_count` = `DEPTH`.

## Structure
- Package `Types`:
  - `rs_row_struct`, `rename_struct`, `word`, `p_reg`, `rob_idx`;
  - new `fu_class_e {FU_ALU, FU_MEM}`.
- Sub-module `iq_select`: age matrix + ready vector + class mask → one-hot oldest grant. Instantiated once per port with cumulative masking.

## Test plan
- **Basic issue.** After reset, dispatch 2 ADDs with all sources ready (ROB 0, 1), `i_fu_ready` = 3'b111 → both issue one cycle later on ports 0 and 1, `fu` = 0/1. `o_free_count` returns to 16.
- **Wakeup.** Dispatch ADD with Src0 = p40 not ready. Wake p40 with data 0x0000_00AA two cycles later → issue the following cycle with `src0` = 0xAA.
- **Same-cycle wake.** Dispatch ADD with Src0 = p40 while p40 is woken the same cycle → entry captures the wake data and issues one cycle later.
- **Fill and back-pressure.** Dispatch 16 not-ready instructions → `o_disp_ready` = 0 once 15 are held. Wake all → oldest-first issue, 2 ALU per cycle. `o_disp_ready` rises once 2 entries are freed.
- **MEM ordering.** Dispatch LW A (Src0 not ready), then LW B (ready) → B does not issue until A issues on port 2.
- **Flush and reset.** With 5 valid entries, pulse `i_flush` → no issue next cycle, `o_free_count` = 16. Drop `i_rst_n` mid-issue → outputs clear immediately.
